// File: rtl/buffer_tra_spi_data.sv
// Transmit-side SPI frame buffer: latches one command frame and streams its payload bytes
// with byte addresses over a valid/ready handshake. Optional abort timer: SPI_TX_TIMEOUT_EN.
module buffer_tra_spi_data #(
    parameter int N_BYTES_MAX    = 5,
    parameter int FIRST_ADDR     = 3,
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               spi_select_in,
    input  logic [7:0]               spi_id_in,
    input  logic [7:0]               spi_reg_in,
    input  logic [8*N_BYTES_MAX-1:0] data_tra_in,
    input  logic [2:0]               n_bytes,
    input  logic                     byte_ready,
    output logic [7:0]               spi_select_out,
    output logic [7:0]               spi_id_out,
    output logic [7:0]               spi_reg_out,
    output logic [ADDR_W-1:0]        addr,
    output logic [7:0]               data_tra_out,
    output logic                     byte_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err
);

    localparam int DATA_W = 8 * N_BYTES_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [7:0]          sel_q, id_q, reg_q;
    logic [DATA_W-1:0]   data_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          rem_q;
    logic [2:0]          n_clamped;
    logic                xfer;
    logic                timeout_hit;

    assign n_clamped = (n_bytes > 3'(N_BYTES_MAX)) ? 3'(N_BYTES_MAX) : n_bytes;
    assign xfer      = (state == SEND) && byte_ready;

`ifdef SPI_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;

    // Abort on the cycle that would have been the TIMEOUT_CYCLES-th stalled one.
    assign timeout_hit = (state == SEND) && !byte_ready
                         && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if ((state != SEND) || byte_ready || timeout_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // NOTE: state and frame registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation results.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: state_nx gets a default before the case, so no path leaves it unassigned and
    // no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (n_clamped == 3'd0) ? DONE : SEND;
            SEND: begin
                if (timeout_hit)                       state_nx = IDLE;
                else if (byte_ready && rem_q == 3'd1)  state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: the frame registers are few plain flops, not a memory array, so clearing them
    // in reset costs nothing and guarantees all-zero outputs after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            id_q   <= '0;
            reg_q  <= '0;
            data_q <= '0;
            addr_q <= '0;
            rem_q  <= '0;
        end else if (state == IDLE && start) begin
            sel_q  <= spi_select_in;
            id_q   <= spi_id_in;
            reg_q  <= spi_reg_in;
            data_q <= data_tra_in;
            addr_q <= ADDR_W'(FIRST_ADDR);
            rem_q  <= n_clamped;
        end else if (xfer) begin
            // Payload shifts up so the current byte is always the top one.
            data_q <= data_q << 8;
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
        end
    end

    assign spi_select_out = sel_q;
    assign spi_id_out     = id_q;
    assign spi_reg_out    = reg_q;
    assign byte_valid     = (state == SEND);
    assign addr           = byte_valid ? addr_q : '0;
    assign data_tra_out   = byte_valid ? data_q[DATA_W-1 -: 8] : 8'h00;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);

endmodule
